// File: rtl/keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deframes 11-bit frames and
// presents the last two scan codes. Define KEYBOARD_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyb_char,
  output logic        keyb_valid,
  output logic        frame_err
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          r_clk_meta, r_clk_sync, r_clk_prev;
  logic          r_data_meta, r_data_sync;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [TW-1:0] r_to_cnt;
  logic [15:0]   r_char, w_char_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_err, w_err_nxt;
  logic          w_sample;
  logic          w_accept;

  // NOTE: synchronizer flops reset to 1 (the idle PS/2 level) so reset release never fakes a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  assign w_sample = r_clk_prev & ~r_clk_sync;

`ifdef KEYBOARD_RX_PARITY_CHECK_EN
  logic r_parity, w_parity_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_parity <= 1'b0;
    else          r_parity <= w_parity_nxt;
  end

  always_comb begin
    w_parity_nxt = r_parity;
    if (w_sample && r_state == PARITY) w_parity_nxt = r_data_sync;
  end

  // Odd parity: data bits plus parity bit must carry an odd number of ones.
  assign w_accept = ^{r_shift, r_parity};
`else
  assign w_accept = 1'b1;
`endif

  // NOTE: every register update uses <= so all flops see pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_char    <= 16'd0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_char    <= w_char_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Idle-gap counter: cleared by activity, saturates at the limit instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_to_cnt <= '0;
    else if (w_sample || r_state == IDLE) r_to_cnt <= '0;
    else if (r_to_cnt != TO_LIMIT)        r_to_cnt <= r_to_cnt + 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_char_nxt    = r_char;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;

    if (w_sample) begin
      unique case (r_state)
        IDLE: begin
          if (!r_data_sync) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = 3'd0;
            w_shift_nxt   = 8'd0;
          end
        end
        DATA: begin
          w_shift_nxt = {r_data_sync, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) w_state_nxt   = PARITY;
          else                   w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        end
        PARITY: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          if (r_data_sync && w_accept) begin
            w_char_nxt  = {r_char[7:0], r_shift};
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_to_cnt == TO_LIMIT) begin
      // A stalled partial frame is dropped; a sample in the same cycle takes priority above.
      w_state_nxt   = IDLE;
      w_bit_cnt_nxt = 3'd0;
      w_shift_nxt   = 8'd0;
      w_err_nxt     = 1'b1;
    end
  end

  assign keyb_char  = {16'h0000, r_char};
  assign keyb_valid = r_valid;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_keyboard_rx.sv
// Directed testbench for keyboard_rx: PS/2 frames driven bit by bit, outputs compared
// against hand-computed scan-code words and pulse counts.
module tb_keyboard_rx;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyb_char;
  logic        keyb_valid;
  logic        frame_err;

  int  n_vec = 0, n_miss = 0;
  int  n_valid = 0, n_err = 0, n_both = 0;
  int  v0, e0;
  time t_fall = 0, t_stop_fall = 0, t_valid = 0, t_err = 0;
  time t_delta;

  always #5 clk = ~clk;

  keyboard_rx #(.TIMEOUT_CYCLES(50)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keyb_char  (keyb_char),
    .keyb_valid (keyb_valid),
    .frame_err  (frame_err)
  );

  // Pulse bookkeeping, sampled on the falling clk edge away from DUT updates.
  always @(negedge clk) begin
    if (keyb_valid) begin n_valid++; t_valid = $time; end
    if (frame_err)  begin n_err++;   t_err   = $time; end
    if (keyb_valid && frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    #40 ps2_clk = 1'b0;
    t_fall = $time;
    #80 ps2_clk = 1'b1;
    #40;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(s);
    t_stop_fall = t_fall;
    ps2_data = 1'b1;
    #200;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_char",  keyb_char,  32'h0);
    check("reset_valid", {31'b0, keyb_valid}, 32'h0);
    check("reset_err",   {31'b0, frame_err},  32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single good frame 0x1C (odd parity bit = 0)
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("f1c_char",  keyb_char, 32'h0000_001C);
    check("f1c_valid", n_valid - v0, 1);
    check("f1c_err",   n_err - e0, 0);
    t_delta = t_valid - t_stop_fall;
    check("f1c_latency_le4", {31'b0, (t_delta > 0 && t_delta <= 40)}, 32'h1);

    // Back-to-back frames 0xF0 (parity 1) then 0x1C
    v0 = n_valid; e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i >= 4);
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("b2b_char",  keyb_char, 32'h0000_F01C);
    check("b2b_valid", n_valid - v0, 2);
    check("b2b_err",   n_err - e0, 0);

    // Bad stop bit
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("stop0_char",  keyb_char, 32'h0000_F01C);
    check("stop0_err",   n_err - e0, 1);
    check("stop0_valid", n_valid - v0, 0);

    // Wrong parity bit
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef KEYBOARD_RX_PARITY_CHECK_EN
    check("par_char",  keyb_char, 32'h0000_F01C);
    check("par_err",   n_err - e0, 1);
    check("par_valid", n_valid - v0, 0);
`else
    check("par_char",  keyb_char, 32'h0000_1C1C);
    check("par_err",   n_err - e0, 0);
    check("par_valid", n_valid - v0, 1);
`endif

    // Timeout after start + 4 data bits of 0x1C, then recovery with 0x32
    v0 = n_valid; e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    for (int k = 0; k < 100 && n_err == e0; k++) @(negedge clk);
    check("to_err",   n_err - e0, 1);
    check("to_valid", n_valid - v0, 0);
    t_delta = t_err - t_fall;
    check("to_delay_window", {31'b0, (t_delta >= 500 && t_delta <= 560)}, 32'h1);
    send_frame(8'h32, 1'b0, 1'b1);
    check("to_next_char", keyb_char, 32'h0000_1C32);

    // Reset mid-frame after 3 data bits of 0x1C, then 0x29
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_char",  keyb_char, 32'h0);
    check("rst_valid", {31'b0, keyb_valid}, 32'h0);
    check("rst_err",   {31'b0, frame_err},  32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    v0 = n_valid; e0 = n_err;
    send_frame(8'h29, 1'b0, 1'b1);
    check("rst_next_char",  keyb_char, 32'h0000_0029);
    check("rst_next_valid", n_valid - v0, 1);
    check("rst_next_err",   n_err - e0, 0);

    check("never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
